ss_digit_sched: RTL and testbench
=================================

Name: ss_digit_sched

Overview:
Sequencer that shares one combinational hex-to-seven-segment decoder across DIGITS display positions on the board.
- On a load request it captures a multi-nibble value plus a blanking mask.
- It drives each nibble through the shared decoder in turn, collecting the segment patterns in staging registers.
- It commits all positions to the display outputs in one cycle.
- Optional periodic refresh re-runs the scan from the held value.
- Sits between user logic (switch/counter sources) and the HEX display pins; the decoder instance stays outside.

Parameters:
DIGITS, 6, number of display positions served (1..8)
SEG_W, 7, segment bits per position (active-low, bit6=g .. bit0=a)
REFRESH_DIV, 0, idle cycles between automatic rescans; 0 disables refresh

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
value  input  4*DIGITS  nibbles to show; position i = value[4i+3:4i]
blank  input  DIGITS  1 = force position i dark (7'h7F)
load  input  1  single-cycle request to scan value/blank
dec_nib  output  4  nibble presented to the shared decoder
dec_seg  input  SEG_W  decoder result for dec_nib (combinational, same cycle)
ss_out  output  SEG_W*DIGITS  committed segment patterns; position i = ss_out[7i+6:7i]
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse on the commit cycle

Behaviour:
Interface:
- One clock, clk; reset is synchronous and active-high, rst.
- Reset (sampled on a clk edge while rst=1):
  - ss_out all 7'h7F; staging all 7'h7F.
  - dec_nib 0; busy 0; done 0; pending 0.
  - Refresh counter 0; shadow value/blank 0; state IDLE.
- rst mid-scan aborts at once; no commit occurs.

FSM states: IDLE, DRIVE, CAPT, COMMIT.
- IDLE:
  - load=1 → shadow_value<=value, shadow_blank<=blank, idx<=0, go to DRIVE.
  - Else, when REFRESH_DIV≠0 and the refresh counter reaches REFRESH_DIV-1 → idx<=0, go to DRIVE, with shadow unchanged.
  - Refresh counter counts only in IDLE and clears on leaving IDLE.
- DRIVE: dec_nib = shadow nibble[idx]; go to CAPT.
- CAPT: dec_nib held.
  - staging[idx] <= shadow_blank[idx] ? 7'h7F : dec_seg.
  - If idx==DIGITS-1 → COMMIT; else idx++ and go to DRIVE.
- COMMIT:
  - ss_out <= staging (all positions in one edge); done=1 for this cycle.
  - If pending=1 → load the pending capture into shadow, clear pending, idx<=0, go to DRIVE.
  - Else go to IDLE.

busy:
- busy=1 in DRIVE, CAPT and COMMIT (registered from next state).
- busy=0 in IDLE.

Latency:
- load sampled at edge k → done high during cycle k+2*DIGITS+1 (13 cycles for DIGITS=6).
- ss_out changes on the edge that ends that cycle.
- ss_out never shows a partially updated set.

load while busy:
- value/blank are captured into the pending registers and pending is set.
- A later load while busy overwrites them (latest wins).
- Refresh is suppressed while pending=1.

Simultaneous load and refresh expiry in IDLE: load wins; the counter clears.

dec_nib: holds its last value in IDLE (no toggling).

Decomposition:
- Package ss_pkg:
  - state enum {IDLE, DRIVE, CAPT, COMMIT}.
  - SEG_W=7.
  - SEG_BLANK=7'h7F.
  - NIB_W=4.
- One natural sub-module, ss_refresh_timer:
  - Parameterised REFRESH_DIV; inputs clk, rst, run.
  - Output expire pulse.
  - Tied off when REFRESH_DIV=0.
- The hex decoder is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use DIGITS=6 and the team's hex decoder model on dec_nib/dec_seg.
1. Reset → ss_out = 42'h3FF_FFFF_FFFF (all 7'h7F), busy=0, done=0; hold rst 3 cycles mid-scan → still all blank, no done.
2. load=1 with value=24'h012345, blank=0 → busy next cycle, done exactly 13 cycles after load.
   - After commit: pos0=7'h12, pos1=7'h19, pos2=7'h30, pos3=7'h24, pos4=7'h79, pos5=7'h40.
   - ss_out unchanged before the done cycle.
3. value=24'h999999, blank=6'b101010 → positions 1,3,5 = 7'h7F; positions 0,2,4 = 7'h10.
4. load (value 24'h111111), then at cycles 3 and 5 load 24'h222222 then 24'h888888.
   - First done shows all 7'h79.
   - Back-to-back rescan with no IDLE cycle; second done 13 cycles later shows all 7'h00; exactly two done pulses.
5. REFRESH_DIV=8:
   - After a scan, idle 8 cycles → autonomous scan; done pulses, ss_out unchanged, dec_nib sequence 5,4,3,2,1,0 for 24'h012345.
   - load on the expiry cycle → load's value is used.
6. Reset asserted during CAPT of idx 3 with new value 24'h777777 → ss_out reverts to blank, never shows 7'h78.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment digit scheduler.
package ss_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CAPT   = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/ss_digit_sched_if.sv
// User-side request/display bundle plus the shared-decoder link of the scheduler.
interface ss_digit_sched_if #(
  parameter int DIGITS = 6
);
  import ss_pkg::*;

  logic [NIB_W*DIGITS-1:0] value;
  logic [DIGITS-1:0]       blank;
  logic                    load;
  logic [NIB_W-1:0]        dec_nib;
  logic [SEG_W-1:0]        dec_seg;
  logic [SEG_W*DIGITS-1:0] ss_out;
  logic                    busy;
  logic                    done;

  modport master (
    output value, blank, load, dec_seg,
    input  dec_nib, ss_out, busy, done
  );

  modport slave (
    input  value, blank, load, dec_seg,
    output dec_nib, ss_out, busy, done
  );

endinterface

// File: rtl/ss_refresh_timer.sv
// Idle-time counter that pulses expire after REFRESH_DIV consecutive run cycles.
module ss_refresh_timer #(
  parameter int REFRESH_DIV = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  generate
    if (REFRESH_DIV > 0) begin : g_timer
      localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             hit_s;

      // Count while running; restart on expiry or whenever run drops.
      always_comb begin
        hit_s = run && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        if (!run || hit_s) begin
          cnt_d = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= {CNT_W{1'b0}};
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire = hit_s;
    end else begin : g_off
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, run};
      assign expire    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ss_digit_sched.sv
// Time-shares one external hex decoder across DIGITS positions, committing all
// decoded patterns to the display in a single cycle.
module ss_digit_sched
  import ss_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 0
) (
  input  logic            clk,
  input  logic            rst,
  ss_digit_sched_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [DIGITS-1:0][NIB_W-1:0]     shadow_value_q, shadow_value_d;
  logic [DIGITS-1:0]                shadow_blank_q, shadow_blank_d;
  logic [DIGITS-1:0][NIB_W-1:0]     pend_value_q, pend_value_d;
  logic [DIGITS-1:0]                pend_blank_q, pend_blank_d;
  logic                             pending_q, pending_d;
  logic [DIGITS-1:0][SEG_W-1:0]     staging_q, staging_d;
  logic [DIGITS-1:0][SEG_W-1:0]     ss_out_q, ss_out_d;
  logic [NIB_W-1:0]                 dec_nib_q, dec_nib_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             last_idx_s;
  logic                             refresh_run_s;
  logic                             refresh_expire_s;

  // A pending request must not be overtaken by an autonomous rescan.
  assign refresh_run_s = (state_q == IDLE) && !pending_q;

  ss_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh (
    .clk    (clk),
    .rst    (rst),
    .run    (refresh_run_s),
    .expire (refresh_expire_s)
  );

  // Scan sequencing, request capture and output staging.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shadow_value_d = shadow_value_q;
    shadow_blank_d = shadow_blank_q;
    pend_value_d   = pend_value_q;
    pend_blank_d   = pend_blank_q;
    pending_d      = pending_q;
    staging_d      = staging_q;
    ss_out_d       = ss_out_q;
    last_idx_s     = (idx_q == IDX_W'(DIGITS - 1));

    if (bus.load && (state_q != IDLE)) begin
      pend_value_d = bus.value;
      pend_blank_d = bus.blank;
      pending_d    = 1'b1;
    end else begin
      pending_d    = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shadow_value_d = bus.value;
          shadow_blank_d = bus.blank;
          idx_d          = {IDX_W{1'b0}};
          state_d        = DRIVE;
        end else if (refresh_expire_s) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        state_d = CAPT;
      end
      CAPT: begin
        staging_d[idx_q] = shadow_blank_q[idx_q] ? SEG_BLANK : bus.dec_seg;
        if (last_idx_s) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DRIVE;
        end
      end
      COMMIT: begin
        ss_out_d = staging_q;
        // A load arriving on the commit cycle is newer than anything pending.
        if (bus.load) begin
          shadow_value_d = bus.value;
          shadow_blank_d = bus.blank;
          pending_d      = 1'b0;
          idx_d          = {IDX_W{1'b0}};
          state_d        = DRIVE;
        end else if (pending_q) begin
          shadow_value_d = pend_value_q;
          shadow_blank_d = pend_blank_q;
          pending_d      = 1'b0;
          idx_d          = {IDX_W{1'b0}};
          state_d        = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == COMMIT);
    if (state_d == DRIVE) begin
      dec_nib_d = shadow_value_d[idx_d];
    end else begin
      dec_nib_d = dec_nib_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= {IDX_W{1'b0}};
      shadow_value_q <= {(NIB_W*DIGITS){1'b0}};
      shadow_blank_q <= {DIGITS{1'b0}};
      pend_value_q   <= {(NIB_W*DIGITS){1'b0}};
      pend_blank_q   <= {DIGITS{1'b0}};
      pending_q      <= 1'b0;
      staging_q      <= {DIGITS{SEG_BLANK}};
      ss_out_q       <= {DIGITS{SEG_BLANK}};
      dec_nib_q      <= {NIB_W{1'b0}};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_blank_q <= shadow_blank_d;
      pend_value_q   <= pend_value_d;
      pend_blank_q   <= pend_blank_d;
      pending_q      <= pending_d;
      staging_q      <= staging_d;
      ss_out_q       <= ss_out_d;
      dec_nib_q      <= dec_nib_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.ss_out  = ss_out_q;
  assign bus.dec_nib = dec_nib_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_ss_digit_sched.sv
// Directed and randomized checks of ss_digit_sched against a display-level model.
module tb_ss_digit_sched;

  localparam logic [41:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;

  logic clk;
  logic rst;
  logic rst_r;
  int   checks;
  int   errors;
  logic [41:0] cur_exp;

  ss_digit_sched_if #(.DIGITS(6)) bus_a ();
  ss_digit_sched_if #(.DIGITS(6)) bus_r ();

  ss_digit_sched #(.DIGITS(6), .REFRESH_DIV(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ss_digit_sched #(.DIGITS(6), .REFRESH_DIV(8)) dut_r (
    .clk (clk),
    .rst (rst_r),
    .bus (bus_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Team decoder model on the shared-decoder link of each instance.
  always_comb bus_a.dec_seg = hex7(bus_a.dec_nib);
  always_comb bus_r.dec_seg = hex7(bus_r.dec_nib);

  // What the display should show once a value/blank pair has been committed.
  function automatic logic [41:0] exp_ss(input logic [23:0] v, input logic [5:0] b);
    logic [41:0] r;
    r = 42'd0;
    for (int i = 0; i < 6; i++) begin
      r[7*i +: 7] = b[i] ? 7'h7F : hex7(v[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan on the main instance: latency, no early update, final image.
  task automatic scan(input logic [23:0] v, input logic [5:0] b, input string tag);
    int   n;
    logic early;
    early       = 1'b0;
    bus_a.value = v;
    bus_a.blank = b;
    bus_a.load  = 1'b1;
    tick();
    bus_a.load  = 1'b0;
    n = 1;
    while ((bus_a.done !== 1'b1) && (n < 40)) begin
      if ((bus_a.ss_out !== cur_exp) || (bus_a.busy !== 1'b1)) early = 1'b1;
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd13);
    check({tag, "_hold"}, 64'(early), 64'd0);
    check({tag, "_pre_commit"}, 64'(bus_a.ss_out), 64'(cur_exp));
    tick();
    cur_exp = exp_ss(v, b);
    check({tag, "_ss_out"}, 64'(bus_a.ss_out), 64'(cur_exp));
    check({tag, "_busy_off"}, 64'(bus_a.busy), 64'd0);
    check({tag, "_done_off"}, 64'(bus_a.done), 64'd0);
  endtask

  initial begin
    logic [6:0]  t2 [6];
    logic        bad;
    int          ndone;
    int          first_done;
    int          second_done;
    logic [23:0] rv;
    logic [5:0]  rb;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    rst_r = 1'b1;
    bus_a.value = 24'd0; bus_a.blank = 6'd0; bus_a.load = 1'b0;
    bus_r.value = 24'd0; bus_r.blank = 6'd0; bus_r.load = 1'b0;
    cur_exp = ALL_BLANK;

    // 1. reset state, then reset held 3 cycles mid-scan
    repeat (3) tick();
    check("rst_ss_out", 64'(bus_a.ss_out), 64'(ALL_BLANK));
    check("rst_busy", 64'(bus_a.busy), 64'd0);
    check("rst_done", 64'(bus_a.done), 64'd0);
    check("rst_dec_nib", 64'(bus_a.dec_nib), 64'd0);
    rst = 1'b0;
    bus_a.value = 24'h012345;
    bus_a.load  = 1'b1;
    tick();
    bus_a.load  = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((bus_a.done !== 1'b0) || (bus_a.busy !== 1'b0) || (bus_a.ss_out !== ALL_BLANK)) bad = 1'b1;
      tick();
    end
    check("rst_abort_quiet", 64'(bad), 64'd0);

    // 2. basic scan with explicit segment constants
    scan(24'h012345, 6'b000000, "t2");
    t2 = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_pos%0d", i), 64'(bus_a.ss_out[7*i +: 7]), 64'(t2[i]));
    end

    // 3. blanking mask
    scan(24'h999999, 6'b101010, "t3");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_pos%0d", i), 64'(bus_a.ss_out[7*i +: 7]),
            64'(((i % 2) == 1) ? 7'h7F : 7'h10));
    end

    // 4. loads while busy: latest pending wins, back-to-back rescan
    ndone = 0; first_done = 0; second_done = 0;
    bus_a.value = 24'h111111; bus_a.blank = 6'd0; bus_a.load = 1'b1;
    tick();
    bus_a.load = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (bus_a.done === 1'b1) begin
        ndone++;
        if (ndone == 1) first_done = n;
        if (ndone == 2) second_done = n;
      end
      if (n == 14) check("t4_first_image", 64'(bus_a.ss_out), 64'(exp_ss(24'h111111, 6'd0)));
      if (n == 27) check("t4_second_image", 64'(bus_a.ss_out), 64'(exp_ss(24'h888888, 6'd0)));
      if (n == 3) begin bus_a.value = 24'h222222; bus_a.load = 1'b1; end
      else if (n == 5) begin bus_a.value = 24'h888888; bus_a.load = 1'b1; end
      else bus_a.load = 1'b0;
      tick();
    end
    check("t4_done_count", 64'(ndone), 64'd2);
    check("t4_first_done", 64'(first_done), 64'd13);
    check("t4_second_done", 64'(second_done), 64'd26);
    cur_exp = exp_ss(24'h888888, 6'd0);

    // randomized scans against the display model
    for (int k = 0; k < 6; k++) begin
      rv = 24'($urandom);
      rb = 6'($urandom_range(0, 63));
      scan(rv, rb, $sformatf("rnd%0d", k));
    end

    // 6. reset during CAPT of idx 3
    bus_a.value = 24'h777777; bus_a.blank = 6'd0; bus_a.load = 1'b1;
    tick();
    bus_a.load = 1'b0;
    repeat (7) tick();
    check("t6_dec_nib_capt3", 64'(bus_a.dec_nib), 64'h7);
    rst = 1'b1;
    tick();
    check("t6_rst_ss_out", 64'(bus_a.ss_out), 64'(ALL_BLANK));
    check("t6_rst_busy", 64'(bus_a.busy), 64'd0);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < 6; p++) begin
        if (bus_a.ss_out[7*p +: 7] === 7'h78) bad = 1'b1;
      end
      if (bus_a.done !== 1'b0) bad = 1'b1;
      tick();
    end
    check("t6_no_partial", 64'(bad), 64'd0);

    // 5. refresh instance: autonomous rescan and load on the expiry cycle
    rst_r = 1'b0;
    bus_r.value = 24'h012345; bus_r.blank = 6'd0; bus_r.load = 1'b1;
    tick();
    bus_r.load = 1'b0;
    bad = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      logic        exp_busy;
      logic        exp_done;
      logic [41:0] exp_img;
      exp_done = (t == 13) || (t == 34) || (t == 55);
      exp_busy = (t <= 13) || ((t >= 22) && (t <= 34)) || ((t >= 43) && (t <= 55));
      exp_img  = (t <= 13) ? ALL_BLANK :
                 (t <= 55) ? exp_ss(24'h012345, 6'd0) : exp_ss(24'habcdef, 6'd0);
      if ((bus_r.done !== exp_done) || (bus_r.busy !== exp_busy) || (bus_r.ss_out !== exp_img)) begin
        bad = 1'b1;
        if (exp_done) check($sformatf("t5_done_t%0d", t), 64'(bus_r.done), 64'(exp_done));
      end
      if ((t >= 22) && (t <= 32) && (((t - 22) % 2) == 0)) begin
        check($sformatf("t5_dec_nib_t%0d", t), 64'(bus_r.dec_nib), 64'(5 - (t - 22) / 2));
      end
      if (t == 42) begin bus_r.value = 24'habcdef; bus_r.load = 1'b1; end
      else bus_r.load = 1'b0;
      tick();
    end
    check("t5_timeline", 64'(bad), 64'd0);
    check("t5_final_image", 64'(bus_r.ss_out), 64'(exp_ss(24'habcdef, 6'd0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
